// File: rtl/regex_pkg.sv
// Shared definitions for the regex byte feeder: character width, AXIS lane
// geometry, feeder state encoding and default header/scan limits.
package regex_pkg;

    localparam int REGEX_CHAR_W           = 8;
    localparam int AXIS_DATA_W            = 256;
    localparam int AXIS_LANES             = AXIS_DATA_W / REGEX_CHAR_W;
    localparam int DEFAULT_HDR_SKIP       = 54;
    localparam int DEFAULT_MAX_SCAN_BYTES = 1024;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FLUSH,
        DRAIN
    } feeder_state_t;

endpackage

// File: rtl/regex_byte_feeder_lane_select.sv
// lane_select: lowest-set-bit priority encoder over the AXIS byte lanes,
// returning the lane index and a flag that any lane is set.
module lane_select
    import regex_pkg::*;
#(
    parameter int LANES = AXIS_LANES,
    parameter int IDX_W = $clog2(LANES)
) (
    input  logic [LANES-1:0] lanes,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        // Scan downwards so the lowest set lane is the one left standing.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lanes[i]) begin
                idx = IDX_W'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regex_byte_feeder.sv
// regex_byte_feeder: strips a fixed header from an AXIS packet stream and
// serialises the payload one byte per cycle for the DFA matcher.
// Optional build macro REGEX_BYTE_FEEDER_STATS_EN adds packet/byte counters.
module regex_byte_feeder
    import regex_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = AXIS_DATA_W,
    parameter int HDR_SKIP            = DEFAULT_HDR_SKIP,
    parameter int MAX_SCAN_BYTES      = DEFAULT_MAX_SCAN_BYTES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    output logic [REGEX_CHAR_W-1:0]          byte_data,
    output logic                             byte_valid,
    input  logic                             byte_ready,
    output logic                             byte_sop,
    output logic                             byte_eop,
    output logic                             byte_null
`ifdef REGEX_BYTE_FEEDER_STATS_EN
    ,
    output logic [31:0]                      stat_pkts,
    output logic [31:0]                      stat_bytes
`endif
);

    localparam int LANES  = C_S_AXIS_DATA_WIDTH / REGEX_CHAR_W;
    localparam int IDX_W  = $clog2(LANES);
    localparam int SKIP_W = $clog2(HDR_SKIP + 1);
    localparam int SCAN_W = $clog2(MAX_SCAN_BYTES + 1);

    feeder_state_t                  state;
    logic [C_S_AXIS_DATA_WIDTH-1:0] buf_data;
    logic [LANES-1:0]               buf_mask;
    logic                           buf_last;
    logic [SKIP_W-1:0]              skip_cnt;
    logic [SCAN_W-1:0]              scan_cnt;
    logic                           first_flag;

    logic [IDX_W-1:0]        emit_idx;
    logic                    emit_hit;
    logic [REGEX_CHAR_W-1:0] emit_byte;
    logic [LANES-1:0]        mask_after;
    logic                    last_lane;
    logic                    trunc;
    logic [LANES-1:0]        skip_mask;
    int                      keep_pop;
    int                      skip_clr;
    logic                    tready_c;
    logic                    xfer;
    logic                    accept;
    logic                    load;
    logic                    retire;

    // Header skip: clear the lowest set lanes one at a time, up to skip_cnt.
    for (genvar k = 0; k < LANES; k++) begin : g_skip
        logic [LANES-1:0] m_in;
        logic [LANES-1:0] m_out;
        logic [IDX_W-1:0] idx;
        logic             hit;
        if (k == 0) begin : g_first
            assign m_in = s_axis_tkeep;
        end else begin : g_next
            assign m_in = g_skip[k-1].m_out;
        end
        lane_select #(.LANES(LANES)) u_sel (.lanes(m_in), .idx(idx), .hit(hit));
        assign m_out = (hit && k < int'(skip_cnt)) ? (m_in & ~(LANES'(1) << idx)) : m_in;
    end
    assign skip_mask = g_skip[LANES-1].m_out;

    always_comb begin
        keep_pop = 0;
        for (int i = 0; i < LANES; i++) keep_pop += int'(s_axis_tkeep[i]);
        skip_clr = (keep_pop < int'(skip_cnt)) ? keep_pop : int'(skip_cnt);
    end

    lane_select #(.LANES(LANES)) u_emit_sel (.lanes(buf_mask), .idx(emit_idx), .hit(emit_hit));

    assign emit_byte  = buf_data[{emit_idx, 3'b000} +: REGEX_CHAR_W];
    assign mask_after = buf_mask & ~(LANES'(1) << emit_idx);
    assign last_lane  = (mask_after == '0);
    assign trunc      = (scan_cnt == SCAN_W'(MAX_SCAN_BYTES - 1));

    always_comb begin
        byte_valid = 1'b0;
        byte_data  = '0;
        byte_eop   = 1'b0;
        byte_null  = 1'b0;
        case (state)
            EMIT: begin
                byte_valid = emit_hit;
                byte_data  = emit_byte;
                byte_eop   = (last_lane && buf_last) || trunc;
            end
            FLUSH: begin
                // A header-only packet still owes the DFA one sop/eop marker.
                if (buf_last && first_flag) begin
                    byte_valid = 1'b1;
                    byte_eop   = 1'b1;
                    byte_null  = 1'b1;
                end
            end
            default: ;
        endcase
        byte_sop = byte_valid && first_flag;
    end

    assign xfer = byte_valid && byte_ready;

    always_comb begin
        case (state)
            IDLE, DRAIN: tready_c = 1'b1;
            // Take the next beat in the cycle the current one empties: no bubble.
            EMIT:        tready_c = xfer && last_lane && !buf_last && !trunc;
            default:     tready_c = 1'b0;
        endcase
        s_axis_tready = tready_c && !reset;
    end

    assign accept = s_axis_tvalid && s_axis_tready;
    assign load   = accept && (state == IDLE || state == EMIT);
    assign retire = (state == EMIT && xfer && buf_last && (last_lane || trunc))
                 || (state == FLUSH && buf_last && (!first_flag || byte_ready))
                 || (state == DRAIN && accept && s_axis_tlast);

    // NOTE: sequential state uses non-blocking assignments only; later
    // assignments in the block deliberately override earlier ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            // NOTE: the wide data buffer is reset too so the block starts empty.
            buf_data   <= '0;
            buf_mask   <= '0;
            buf_last   <= 1'b0;
            skip_cnt   <= SKIP_W'(HDR_SKIP);
            scan_cnt   <= '0;
            first_flag <= 1'b1;
        end else begin
            if (xfer) first_flag <= 1'b0;
            if (state == EMIT && xfer) begin
                buf_mask <= mask_after;
                if (scan_cnt != SCAN_W'(MAX_SCAN_BYTES)) scan_cnt <= scan_cnt + 1'b1;
            end
            if (load) begin
                buf_data <= s_axis_tdata;
                buf_mask <= skip_mask;
                buf_last <= s_axis_tlast;
                skip_cnt <= skip_cnt - SKIP_W'(skip_clr);
            end
            case (state)
                IDLE:  if (accept) state <= (skip_mask != '0) ? EMIT : FLUSH;
                EMIT: begin
                    if (xfer) begin
                        if (trunc)          state <= buf_last ? IDLE : DRAIN;
                        else if (last_lane) state <= !accept ? IDLE
                                                   : (skip_mask != '0) ? EMIT : FLUSH;
                    end
                end
                FLUSH: if (!buf_last || !first_flag || byte_ready) state <= IDLE;
                DRAIN: if (accept && s_axis_tlast) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (retire) begin
                skip_cnt   <= SKIP_W'(HDR_SKIP);
                scan_cnt   <= '0;
                first_flag <= 1'b1;
            end
        end
    end

`ifdef REGEX_BYTE_FEEDER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
        end else begin
            if (retire)              stat_pkts  <= stat_pkts + 32'd1;
            if (xfer && !byte_null)  stat_bytes <= stat_bytes + 32'd1;
        end
    end
`endif

endmodule
